fa_ha_adder: RTL and testbench

- Registered ripple-carry adder. Each bit is a full adder built from two half-adder cells plus an OR gate.
- With WIDTH=1 it is the classic full adder: inputs a, b and carry-in c; outputs sum and carry.
- Used as an arithmetic leaf in datapaths that need a pipelined add with explicit carry-in and carry-out.
- One register stage on the outputs, qualified by a valid strobe.

---
 rtl/fa_ha_pkg.sv | 23 ++
 rtl/fa_ha_adder_ha_cell.sv | 12 +
 rtl/fa_ha_adder.sv | 78 +++++++
 tb/tb_fa_ha_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fa_ha_pkg.sv
// Shared constants and the arithmetic reference for the fa_ha_adder ripple adder.
package fa_ha_pkg;

    localparam int unsigned FA_HA_DEFAULT_WIDTH = 1;
    localparam int unsigned FA_HA_MAX_WIDTH     = 64;

    // Golden {carry, sum} of a + b + c truncated to width operand bits; carry sits at bit [width].
    function automatic logic [FA_HA_MAX_WIDTH:0] fa_ha_golden(
        input logic [FA_HA_MAX_WIDTH-1:0] a,
        input logic [FA_HA_MAX_WIDTH-1:0] b,
        input logic                       c,
        input int unsigned                width
    );
        logic [FA_HA_MAX_WIDTH:0] op_mask;
        logic [FA_HA_MAX_WIDTH:0] res_mask;
        logic [FA_HA_MAX_WIDTH:0] full;
        op_mask  = (65'(1) << width) - 65'(1);
        res_mask = (op_mask << 1) | 65'(1);
        full     = (65'(a) & op_mask) + (65'(b) & op_mask) + 65'(c);
        return full & res_mask;
    endfunction

endpackage

// File: rtl/fa_ha_adder_ha_cell.sv
// Half-adder cell: two of these plus an OR form one full-adder bit.
module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);

    assign s  = x ^ y;
    assign co = x & y;

endmodule

// File: rtl/fa_ha_adder.sv
// Registered ripple-carry adder built from half-adder cells, one output register stage.
// Optional macro FA_HA_OVERFLOW_EN adds a registered two's-complement overflow output.
module fa_ha_adder
    import fa_ha_pkg::*;
#(
    parameter int unsigned WIDTH = FA_HA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
`ifdef FA_HA_OVERFLOW_EN
    output logic             carry,
    output logic             overflow
`else
    output logic             carry
`endif
);

    if ((WIDTH == 0) || (WIDTH > FA_HA_MAX_WIDTH)) begin : g_bad_width
        $error("fa_ha_adder: WIDTH %0d outside 1..%0d", WIDTH, FA_HA_MAX_WIDTH);
    end

    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] sum_c;

    assign k[0] = c;

    // Per bit: ha0 adds the operands, ha1 folds in the ripple carry.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        ha_cell u_ha0 (
            .x  (a[i]),
            .y  (b[i]),
            .s  (s0[i]),
            .co (c0[i])
        );
        ha_cell u_ha1 (
            .x  (s0[i]),
            .y  (k[i]),
            .s  (sum_c[i]),
            .co (c1[i])
        );
        assign k[i+1] = c0[i] | c1[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= sum_c;
                carry <= k[WIDTH];
            end
        end
    end

`ifdef FA_HA_OVERFLOW_EN
    // Carry into and out of the MSB disagree exactly on signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid) begin
            overflow <= k[WIDTH] ^ k[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_fa_ha_adder.sv
// Self-checking bench: WIDTH=1/8/32 adders side by side against an arithmetic model.
module tb_fa_ha_adder;
    import fa_ha_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        c;

    logic        ov1, ov8, ov32;
    logic [0:0]  s1;
    logic [7:0]  s8;
    logic [31:0] s32;
    logic        cy1, cy8, cy32;
`ifdef FA_HA_OVERFLOW_EN
    logic        of1, of8, of32;
`endif

    int unsigned total;
    int unsigned bad;

    int unsigned wid [3];
    logic        exp_valid;
    logic [63:0] exp_sum [3];
    logic        exp_carry [3];
    logic        exp_ovf [3];

    fa_ha_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]), .c(c),
        .out_valid(ov1), .sum(s1),
`ifdef FA_HA_OVERFLOW_EN
        .overflow(of1),
`endif
        .carry(cy1)
    );
    fa_ha_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[7:0]), .b(b[7:0]), .c(c),
        .out_valid(ov8), .sum(s8),
`ifdef FA_HA_OVERFLOW_EN
        .overflow(of8),
`endif
        .carry(cy8)
    );
    fa_ha_adder #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[31:0]), .b(b[31:0]), .c(c),
        .out_valid(ov32), .sum(s32),
`ifdef FA_HA_OVERFLOW_EN
        .overflow(of32),
`endif
        .carry(cy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Signed overflow from the two's-complement value range, not from carries.
    function automatic logic signed_ovf(input logic [63:0] av, input logic [63:0] bv,
                                        input logic cv, input int unsigned w);
        longint span, lo, hi, sa, sb, r;
        longint ua, ub;
        span = longint'(1) << w;
        ua   = longint'(av & 64'(span - 1));
        ub   = longint'(bv & 64'(span - 1));
        sa   = (ua >= span / 2) ? ua - span : ua;
        sb   = (ub >= span / 2) ? ub - span : ub;
        lo   = -(span / 2);
        hi   = span / 2 - 1;
        r    = sa + sb + longint'(cv);
        return (r < lo) || (r > hi);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".v1"},  64'(ov1),  64'(exp_valid));
        chk({tag, ".v8"},  64'(ov8),  64'(exp_valid));
        chk({tag, ".v32"}, 64'(ov32), 64'(exp_valid));
        chk({tag, ".s1"},  64'(s1),   exp_sum[0]);
        chk({tag, ".s8"},  64'(s8),   exp_sum[1]);
        chk({tag, ".s32"}, 64'(s32),  exp_sum[2]);
        chk({tag, ".c1"},  64'(cy1),  64'(exp_carry[0]));
        chk({tag, ".c8"},  64'(cy8),  64'(exp_carry[1]));
        chk({tag, ".c32"}, 64'(cy32), 64'(exp_carry[2]));
`ifdef FA_HA_OVERFLOW_EN
        chk({tag, ".o1"},  64'(of1),  64'(exp_ovf[0]));
        chk({tag, ".o8"},  64'(of8),  64'(exp_ovf[1]));
        chk({tag, ".o32"}, 64'(of32), 64'(exp_ovf[2]));
`endif
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_sum[i]   = '0;
            exp_carry[i] = 1'b0;
            exp_ovf[i]   = 1'b0;
        end
    endtask

    // One clock: drive at negedge, update model at posedge, sample 1 time unit later.
    task automatic step(input string tag, input logic v, input logic [63:0] av,
                        input logic [63:0] bv, input logic cv);
        logic [64:0] g;
        @(negedge clk);
        in_valid = v;
        a = av;
        b = bv;
        c = cv;
        @(posedge clk);
        exp_valid = v;
        if (v) begin
            for (int i = 0; i < 3; i++) begin
                g = fa_ha_golden(av, bv, cv, wid[i]);
                exp_carry[i] = g[wid[i]];
                exp_sum[i]   = g[63:0] & ((64'(1) << wid[i]) - 64'(1));
                exp_ovf[i]   = signed_ovf(av, bv, cv, wid[i]);
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [1:0]  tbl1 [8];
        logic [63:0] ra, rb;
        total = 0;
        bad   = 0;
        wid[0] = 1;
        wid[1] = 8;
        wid[2] = 32;
        tbl1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        c = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 exhaustive truth table
        for (int n = 0; n < 8; n++) begin
            step("fa", 1'b1, 64'((n >> 2) & 1), 64'((n >> 1) & 1), 1'((n & 1)));
            chk("fa_tbl", 64'({cy1, s1}), 64'(tbl1[n]));
        end

        // Carry ripple across all 8 bits
        step("rip0", 1'b1, 64'hFF, 64'h01, 1'b0);
        chk("rip0_sum", 64'(s8), 64'h00);
        chk("rip0_cy", 64'(cy8), 64'h1);
        step("rip1", 1'b1, 64'hFF, 64'hFF, 1'b1);
        chk("rip1_sum", 64'(s8), 64'hFF);
        chk("rip1_cy", 64'(cy8), 64'h1);

        // Hold while in_valid is low
        step("load", 1'b1, 64'h12, 64'h34, 1'b1);
        chk("load_sum", 64'(s8), 64'h47);
        for (int n = 0; n < 5; n++) begin
            step("hold", 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            chk("hold_sum", 64'(s8), 64'h47);
            chk("hold_cy", 64'(cy8), 64'h0);
            chk("hold_vld", 64'(ov8), 64'h0);
        end

        // Asynchronous reset between edges
        step("reload", 1'b1, 64'h12, 64'h34, 1'b1);
        chk("reload_vld", 64'(ov8), 64'h1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        chk("arst_sum", 64'(s8), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("post", 1'b1, 64'h3, 64'h4, 1'b0);
        chk("post_sum", 64'(s8), 64'h7);

`ifdef FA_HA_OVERFLOW_EN
        step("ov0", 1'b1, 64'h7F, 64'h01, 1'b0);
        chk("ov0_sum", 64'(s8), 64'h80);
        chk("ov0_of", 64'(of8), 64'h1);
        chk("ov0_cy", 64'(cy8), 64'h0);
        step("ov1", 1'b1, 64'h80, 64'h80, 1'b0);
        chk("ov1_sum", 64'(s8), 64'h00);
        chk("ov1_of", 64'(of8), 64'h1);
        chk("ov1_cy", 64'(cy8), 64'h1);
        step("ov2", 1'b1, 64'h05, 64'hFB, 1'b0);
        chk("ov2_of", 64'(of8), 64'h0);
`endif

        // Random regression, mixing valid and idle cycles
        for (int n = 0; n < 10000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ((n % 16) == 0) begin
                ra = '1;
                rb = (n % 32 == 0) ? 64'h0 : '1;
            end
            step("rnd", 1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
